// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle barrel-shifter replacement for operand-2 generation.
// Accepts one request at a time, shifts one bit per cycle in SHIFT, and holds the
// result in DONE until the consumer takes it.
// Optional feature: define SHIFT_SEQ_RRX_EN to turn an immediate ROR #0 into RRX.
module shift_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       shifter_op,
    input  logic [1:0]       by_imm_shift,
    input  logic [WIDTH-1:0] A,
    input  logic [11:0]      B,
    input  logic             c_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] shift_result,
    output logic             C,
    output logic             busy
);

    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] OP_IMM_SHIFT = 3'b000;
    localparam logic [2:0] OP_ROT_IMM   = 3'b001;
    localparam logic [2:0] OP_IMM_OFS   = 3'b010;
    localparam logic [2:0] OP_REG_OFS   = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    state_e           state, state_n;
    mode_e            mode, mode_n;
    logic [WIDTH-1:0] work, work_n;
    logic [CNT_W-1:0] count, count_n;
    logic             fill, fill_n;
    logic [WIDTH-1:0] result_n;
    logic             carry_n;
    logic [WIDTH-1:0] step_val;
    logic             step_bit;
`ifdef SHIFT_SEQ_RRX_EN
    logic             rrx, rrx_n;
    logic             rrx_cin, rrx_cin_n;
`endif

    // Request side may only hand over work while idle and out of reset
    assign req_ready = (state == IDLE) && !reset;

    // One-bit step of the working value in the captured mode
    always_comb begin
        step_val = work;
        step_bit = work[0];
        case (mode)
            MODE_LSL: begin
                step_val = {work[WIDTH-2:0], 1'b0};
                step_bit = work[WIDTH-1];
            end
            MODE_LSR: step_val = {1'b0, work[WIDTH-1:1]};
            MODE_ASR: step_val = {fill, work[WIDTH-1:1]};
            MODE_ROR: step_val = {work[0], work[WIDTH-1:1]};
            default:  step_val = work;
        endcase
`ifdef SHIFT_SEQ_RRX_EN
        if (rrx) begin
            step_val = {rrx_cin, work[WIDTH-1:1]};
            step_bit = work[0];
        end
`endif
    end

    // Next-state and datapath update
    always_comb begin
        state_n  = state;
        mode_n   = mode;
        work_n   = work;
        count_n  = count;
        fill_n   = fill;
        result_n = shift_result;
        carry_n  = C;
`ifdef SHIFT_SEQ_RRX_EN
        rrx_n     = rrx;
        rrx_cin_n = rrx_cin;
`endif
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
`ifdef SHIFT_SEQ_RRX_EN
                    rrx_n     = 1'b0;
                    rrx_cin_n = c_in;
`endif
                    case (shifter_op)
                        OP_IMM_SHIFT: begin
                            work_n  = A;
                            count_n = B[11:7];
                            mode_n  = mode_e'(by_imm_shift);
                            fill_n  = A[WIDTH-1];
                            if (B[11:7] != '0) begin
                                state_n = SHIFT;
                            end
`ifdef SHIFT_SEQ_RRX_EN
                            else if (by_imm_shift == 2'b11) begin
                                // ROR #0 encodes RRX: a single step through the carry
                                rrx_n   = 1'b1;
                                count_n = CNT_W'(1);
                                state_n = SHIFT;
                            end
`endif
                            else begin
                                result_n = A;
                                carry_n  = c_in;
                                state_n  = DONE;
                            end
                        end
                        OP_ROT_IMM: begin
                            work_n  = WIDTH'(B[7:0]);
                            count_n = {B[11:8], 1'b0};
                            mode_n  = MODE_ROR;
                            fill_n  = 1'b0;
                            if (B[11:8] != '0) begin
                                state_n = SHIFT;
                            end else begin
                                result_n = WIDTH'(B[7:0]);
                                carry_n  = c_in;
                                state_n  = DONE;
                            end
                        end
                        OP_IMM_OFS: begin
                            result_n = WIDTH'(B);
                            carry_n  = c_in;
                            state_n  = DONE;
                        end
                        OP_REG_OFS: begin
                            result_n = WIDTH'(B[3:0]);
                            carry_n  = c_in;
                            state_n  = DONE;
                        end
                        default: begin
                            result_n = '0;
                            carry_n  = c_in;
                            state_n  = DONE;
                        end
                    endcase
                end
            end
            SHIFT: begin
                work_n  = step_val;
                count_n = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    result_n = step_val;
                    carry_n  = step_bit;
                    state_n  = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            mode         <= MODE_LSL;
            work         <= '0;
            count        <= '0;
            fill         <= 1'b0;
            shift_result <= '0;
            C            <= 1'b0;
            rsp_valid    <= 1'b0;
            busy         <= 1'b0;
`ifdef SHIFT_SEQ_RRX_EN
            rrx          <= 1'b0;
            rrx_cin      <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            mode         <= mode_n;
            work         <= work_n;
            count        <= count_n;
            fill         <= fill_n;
            shift_result <= result_n;
            C            <= carry_n;
            rsp_valid    <= (state_n == DONE);
            busy         <= (state_n != IDLE);
`ifdef SHIFT_SEQ_RRX_EN
            rrx          <= rrx_n;
            rrx_cin      <= rrx_cin_n;
`endif
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed cases plus random requests,
// with a reference model built from plain shift arithmetic.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  shifter_op;
    logic [1:0]  by_imm_shift;
    logic [31:0] A;
    logic [11:0] B;
    logic        c_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] shift_result;
    logic        C;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        car;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          ready_hold = 0;
    bit          started = 0;
    logic [31:0] last_res = '0;
    logic        last_c = 1'b0;

    shift_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .shifter_op(shifter_op), .by_imm_shift(by_imm_shift), .A(A), .B(B),
        .c_in(c_in), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .shift_result(shift_result), .C(C), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: result, carry and extra SHIFT cycles computed from the operand rules
    function automatic void model(input logic [2:0] op, input logic [1:0] md,
                                  input logic [31:0] a, input logic [11:0] b, input logic ci,
                                  output logic [31:0] res, output logic car, output int lat);
        int          n;
        logic [31:0] w;
        res = '0; car = ci; lat = 0;
        if (op == 3'd0 || op == 3'd1) begin
            if (op == 3'd0) begin n = int'(b[11:7]); w = a; end
            else begin n = 2 * int'(b[11:8]); w = {24'd0, b[7:0]}; md = 2'b11; end
            if (n == 0) begin
                res = w;
`ifdef SHIFT_SEQ_RRX_EN
                if (op == 3'd0 && md == 2'b11) begin
                    res = {ci, w[31:1]}; car = w[0]; lat = 1;
                end
`endif
            end else begin
                lat = n;
                case (md)
                    2'b00: begin res = w << n; car = w[32-n]; end
                    2'b01: begin res = w >> n; car = w[n-1]; end
                    2'b10: begin res = 32'($signed(w) >>> n); car = w[n-1]; end
                    default: begin res = (w >> n) | (w << (32 - n)); car = w[n-1]; end
                endcase
            end
        end else if (op == 3'd2) res = {20'd0, b};
        else if (op == 3'd3) res = {28'd0, b[3:0]};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        started <= 1'b1;
    end

    // A reset edge abandons whatever is in flight
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            last_res = '0;
            last_c = 1'b0;
        end
    end

    // Consumer: random backpressure, forced low while ready_hold runs
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_hold > 0) begin
                rsp_ready = 1'b0;
                ready_hold--;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: handshake/latency invariants each cycle, data against scoreboard head
    always @(negedge clk) begin
        if (started) begin
            chk("busy", 32'(busy), 32'(q.size() > 0));
            chk("rsp_valid", 32'(rsp_valid), 32'(q.size() > 0 && cyc >= q[0].due));
            chk("req_ready", 32'(req_ready), 32'(q.size() == 0 && !reset));
            if (rsp_valid && q.size() > 0) begin
                chk("result", shift_result, q[0].res);
                chk("carry", 32'(C), 32'(q[0].car));
                if (rsp_ready) begin
                    last_res = q[0].res;
                    last_c = q[0].car;
                    void'(q.pop_front());
                end
            end else if (q.size() == 0 || !rsp_valid) begin
                if (q.size() == 0) begin
                    chk("idle_result", shift_result, last_res);
                    chk("idle_carry", 32'(C), 32'(last_c));
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [1:0] md, input logic [31:0] a,
                        input logic [11:0] b, input logic ci);
        logic [31:0] res;
        logic        car;
        int          lat;
        exp_t        e;
        bit          done = 0;
        shifter_op = op; by_imm_shift = md; A = a; B = b; c_in = ci;
        req_valid = 1'b1;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (req_ready) begin
                model(op, md, a, b, ci, res, car, lat);
                e.res = res; e.car = car; e.due = cyc + 1 + lat;
                @(posedge clk);
                q.push_back(e);
                done = 1;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout: got no req_ready expected accept (cycle %0d)", cyc);
        end
        #1;
        req_valid = 1'b0;
        // Scramble operands after capture; the DUT must ignore them
        shifter_op = 3'($urandom); by_imm_shift = 2'($urandom);
        A = $urandom; B = 12'($urandom); c_in = 1'($urandom);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0;
        shifter_op = '0; by_imm_shift = '0; A = '0; B = '0; c_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        send(3'd0, 2'b00, 32'h8000_0001, {5'd1, 7'd0}, 1'b0);
        send(3'd0, 2'b10, 32'h8000_0000, {5'd4, 7'd0}, 1'b1);
        send(3'd1, 2'b00, 32'h0, 12'h4FF, 1'b0);
        ready_hold = 5;
        send(3'd2, 2'b00, 32'h0, 12'hABC, 1'b1);
        send(3'd0, 2'b11, 32'h0000_0003, 12'h000, 1'b1);
        send(3'd0, 2'b01, 32'hFFFF_FFFF, {5'd31, 7'd0}, 1'b0);
        send(3'd3, 2'b00, 32'h0, 12'hFF5, 1'b0);
        send(3'd5, 2'b00, 32'h1234, 12'h123, 1'b1);

        // Reset in the middle of a long LSR: no response may follow
        send(3'd0, 2'b01, 32'hDEAD_BEEF, {5'd20, 7'd0}, 1'b1);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        send(3'd1, 2'b00, 32'h0, 12'h1A5, 1'b0);

        for (int i = 0; i < 150; i++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 9) < 7) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
            send(op, 2'($urandom), $urandom, 12'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        for (int t = 0; t < 300 && q.size() > 0; t++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0 (cycle %0d)", q.size(), cyc);
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, datapath width; only 32 is supported.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  sequencer can accept a request.
REQ-007 shifter_op  input  3  operand class: 000 shift-by-imm, 001 rotated 8-bit imm, 010 imm offset, 011 reg offset.
REQ-008 by_imm_shift  input  2  shift mode for op 000: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-009 A  input  32  register operand.
REQ-010 B  input  12  instruction immediate field.
REQ-011 c_in  input  1  current carry flag.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  consumer takes result.
REQ-014 shift_result  output  32  shifted operand.
REQ-015 C  output  1  shifter carry-out.
REQ-016 busy  output  1  high in SHIFT or DONE.

Function
REQ-017 FSM states: IDLE, SHIFT, DONE; req_ready=1 only in IDLE; rsp_valid=1 only in DONE.
REQ-018 Accept on clk edge with req_valid&&req_ready; operands, mode, count and c_in are captured; later input changes are ignored.
REQ-019 op 000: work=A, count=B[11:7], mode=by_imm_shift, fill bit for ASR=A[31] as captured.
REQ-020 op 001: work={24'b0,B[7:0]}, count=2*B[11:8], mode=ROR.
REQ-021 op 010: result={20'b0,B}; op 011: result={28'b0,B[3:0]}; op 1xx: result=0; all three take C=c_in and go directly to DONE.
REQ-022 For op 000/001, count==0 goes directly to DONE with result=work and C=c_in, except as in REQ-031.
REQ-023 For op 000/001, count>0 goes to SHIFT; each SHIFT cycle performs a one-bit step in the selected mode and decrements count; the step that reaches count 0 enters DONE.
REQ-024 Carry is the last bit shifted out: LSL bit31, LSR/ASR/ROR bit0.
REQ-025 Latency: if accepted in cycle N, rsp_valid is high from cycle N+1+count.
REQ-026 In DONE, shift_result and C are stable until rsp_valid&&rsp_ready, then IDLE; one transaction at a time, no overlap.
REQ-027 shift_result and C are updated only on entry to DONE and retain value in IDLE.
REQ-028 rsp_ready is ignored outside DONE; req_valid is ignored outside IDLE.

Reset
REQ-029 While reset is high at a clk edge: state=IDLE, rsp_valid=0, busy=0, shift_result=0, C=0, count=0; req_ready=0 during the reset cycle.
REQ-030 Reset in SHIFT or DONE abandons the transaction with no response; the next accept is possible in the first non-reset cycle.

Configuration
REQ-031 Macro SHIFT_SEQ_RRX_EN defined: op 000, mode 11, count 0 performs RRX in one SHIFT cycle, giving result={c_in,A[31:1]} and C=A[0], with rsp_valid at N+2.
REQ-032 Macro SHIFT_SEQ_RRX_EN undefined: that case follows REQ-022, giving result=A and C=c_in with rsp_valid at N+1; the RRX logic is absent.

Verification
REQ-033 op000 LSL, A=0x80000001, B[11:7]=1, c_in=0 -> result 0x00000002, C=1, rsp_valid at N+2.
REQ-034 op000 ASR, A=0x80000000, count 4 -> result 0xF8000000, C=0, rsp_valid at N+5, busy high N+1..N+5.
REQ-035 op001, B=0x4FF -> result 0xFF000000, C=1, rsp_valid at N+9.
REQ-036 op010, B=0xABC, rsp_ready low 3 cycles -> result 0x00000ABC held stable, req_ready=0 throughout, IDLE one cycle after the handshake.
REQ-037 op000 LSR count 20, reset high at N+5 -> in N+6, rsp_valid=0, shift_result=0, C=0, no response ever issued.
REQ-038 op000 ROR count 0, A=0x00000003, c_in=1 -> with macro: 0x80000001, C=1 at N+2; without macro: 0x00000003, C=1 at N+1.
